// File: rtl/push_debounce_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
// Defaults target the DE2 board: 50 MHz system clock, 20 ms debounce window.
package push_debounce_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DB_MS         = 20;
    localparam int DB_CYCLES_DEF = (CLK_HZ / 1000) * DB_MS;

    // Bits needed to hold values 0..value-1; callers pass DB_CYCLES+1.
    function automatic int f_clog2(input int value);
        int v;
        int w;
        v = value - 1;
        w = 0;
        while (v > 0) begin
            w = w + 1;
            v = v >>> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/push_debounce_bit.sv
// One button line: 2-flop synchroniser, stable-count debouncer and
// registered one-cycle press/release pulses.
module debounce_bit
    import push_debounce_pkg::*;
#(
    parameter int   DB_CYCLES  = DB_CYCLES_DEF,
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int               CNT_W    = f_clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic             w_s2;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;

    // Synchronised sample normalised so that 1 always means pressed.
    assign w_s2 = r_sync2 ^ ACTIVE_LOW;

    // Debounce decision: accept a change only after DB_CYCLES differing samples.
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_s2 == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt     = '0;
            w_level_nxt   = w_s2;
            w_press_nxt   = w_s2;
            w_release_nxt = ~w_s2;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Synchroniser, counter and output registers; sync flops reset to the released pin level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= ACTIVE_LOW;
            r_sync2   <= ACTIVE_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/push_debounce.sv
// Conditions raw KEY push-button pins for the PUSH PIO in_port: one
// independent synchronise-and-debounce channel per line, active-high outputs.
module push_debounce
    import push_debounce_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release
);

    localparam logic POL_LOW = (ACTIVE_LOW != 0);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        debounce_bit #(
            .DB_CYCLES  (DB_CYCLES),
            .ACTIVE_LOW (POL_LOW)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_raw     (key_raw[g]),
            .o_level   (key_level[g]),
            .o_press   (key_press[g]),
            .o_release (key_release[g])
        );
    end

endmodule

// File: tb/tb_push_debounce.sv
// Bench for push_debounce: a 2-bit active-low DUT (DB_CYCLES=4) and a 1-bit
// active-high DUT (DB_CYCLES=1), both checked against a sliding-window model.
module tb_push_debounce;

    localparam int DB_A = 4;
    localparam int DB_B = 1;
    localparam int NCH  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] raw_a;
    logic [0:0] raw_b;
    logic [1:0] lvl_a, prs_a, rel_a;
    logic [0:0] lvl_b, prs_b, rel_b;

    always #5 clk = ~clk;

    push_debounce #(.WIDTH(2), .DB_CYCLES(DB_A), .ACTIVE_LOW(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .key_raw(raw_a),
        .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a)
    );

    push_debounce #(.WIDTH(1), .DB_CYCLES(DB_B), .ACTIVE_LOW(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .key_raw(raw_b),
        .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: channels 0,1 = dut_a bits, channel 2 = dut_b bit 0.
    bit pq [NCH][$];   // pressed-ness of the pin sampled at each edge since reset
    bit sh [NCH][$];   // value the debouncer sees at each edge (pin delayed two edges)
    bit m_lvl [NCH];
    bit m_prs [NCH];
    bit m_rel [NCH];
    bit in_rst;

    function automatic bit pressed(int ch);
        if (ch < 2) return (raw_a[ch] == 1'b0);
        return (raw_b[0] == 1'b1);
    endfunction

    function automatic int db_of(int ch);
        return (ch < 2) ? DB_A : DB_B;
    endfunction

    // A change is accepted when the last DB samples all disagree with the level.
    task automatic model_edge();
        for (int ch = 0; ch < NCH; ch++) begin
            m_prs[ch] = 1'b0;
            m_rel[ch] = 1'b0;
            if (in_rst) begin
                pq[ch].delete();
                sh[ch].delete();
                m_lvl[ch] = 1'b0;
            end else begin
                bit s2;
                bit all_diff;
                int db;
                db = db_of(ch);
                pq[ch].push_back(pressed(ch));
                s2 = (pq[ch].size() >= 3) ? pq[ch][pq[ch].size() - 3] : 1'b0;
                sh[ch].push_back(s2);
                if (pq[ch].size() > 8) void'(pq[ch].pop_front());
                if (sh[ch].size() > 8) void'(sh[ch].pop_front());
                if (sh[ch].size() >= db) begin
                    all_diff = 1'b1;
                    for (int i = 0; i < db; i++)
                        if (sh[ch][sh[ch].size() - 1 - i] == m_lvl[ch]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_lvl[ch] = ~m_lvl[ch];
                        if (m_lvl[ch]) m_prs[ch] = 1'b1;
                        else           m_rel[ch] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_out(string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        for (int ch = 0; ch < NCH; ch++) begin
            if (ch < 2) obs = {lvl_a[ch], prs_a[ch], rel_a[ch]};
            else        obs = {lvl_b[0], prs_b[0], rel_b[0]};
            exp = {m_lvl[ch], m_prs[ch], m_rel[ch]};
            n_vec++;
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s ch%0d level/press/release observed=%b expected=%b at %0t",
                       tag, ch, obs, exp, $time);
            end
        end
    endtask

    task automatic ticks(string tag, int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_out(tag);
        end
    endtask

    task automatic pulse_reset(string tag, int n);
        reset_n = 1'b0;
        in_rst  = 1'b1;
        model_edge();
        #1;
        check_out({tag, "_async"});
        ticks(tag, n);
        reset_n = 1'b1;
        in_rst  = 1'b0;
    endtask

    initial begin
        raw_a   = 2'b11;
        raw_b   = 1'b0;
        reset_n = 1'b0;
        in_rst  = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            m_lvl[ch] = 1'b0;
            m_prs[ch] = 1'b0;
            m_rel[ch] = 1'b0;
        end
        ticks("reset", 3);
        reset_n = 1'b1;
        in_rst  = 1'b0;

        ticks("idle", 20);

        // Single press and release on bit 0.
        raw_a[0] = 1'b0;
        ticks("press0", 10);
        raw_a[0] = 1'b1;
        ticks("release0", 10);

        // Bounce on bit 1 that never lasts long enough, then a steady press.
        for (int k = 0; k < 3; k++) begin
            raw_a[1] = 1'b0;
            ticks("bounce1_low", 3);
            raw_a[1] = 1'b1;
            ticks("bounce1_high", 1);
        end
        raw_a[1] = 1'b0;
        ticks("steady1", 10);
        raw_a[1] = 1'b1;
        ticks("release1", 10);

        // Simultaneous press, bit 0 released two cycles later.
        raw_a = 2'b00;
        ticks("both", 2);
        raw_a[0] = 1'b1;
        ticks("both_rel0", 12);
        raw_a = 2'b11;
        ticks("both_rel", 10);

        // Held button through resets, mid-count and after acceptance.
        raw_a[0] = 1'b0;
        ticks("hold_pre", 3);
        pulse_reset("rst_mid", 2);
        ticks("hold_post1", 10);
        pulse_reset("rst_acc", 3);
        ticks("hold_post2", 10);
        raw_a = 2'b11;
        ticks("hold_rel", 10);

        // Active-high, DB_CYCLES=1 channel.
        raw_b = 1'b1;
        ticks("b_press", 5);
        raw_b = 1'b0;
        ticks("b_release", 5);

        // Random bouncy and steady activity on all lines.
        for (int r = 0; r < 120; r++) begin
            raw_a = 2'($urandom);
            raw_b = 1'($urandom);
            if ($urandom_range(0, 3) == 0) ticks("rand_hold", int'($urandom_range(6, 12)));
            else                           ticks("rand_bounce", int'($urandom_range(1, 4)));
            if (r == 60) pulse_reset("rand_rst", 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
